// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising XNOR LFSR stream checker with lock FSM and error counting
module lfsr_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int UNLOCK_ERRS = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clear_err,
    output logic        locked,
    output logic        bit_err,
    output logic [31:0] err_count,
    output logic [1:0]  sync_state
);
    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [7:0]    LC    = LOCK_COUNT[7:0];
    localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
    localparam logic [EW-1:0] UE    = EW'(UNLOCK_ERRS);

    logic [1:0]    r_state;
    logic [31:0]   r_h;
    logic [4:0]    r_fill;
    logic [7:0]    r_match;
    logic [WW-1:0] r_win;
    logic [EW-1:0] r_win_errs;
    logic          r_bit_err;
    logic [31:0]   r_err_count;

    logic          w_p;
    logic          w_mis;
    logic          w_err;
    logic [7:0]    w_match_nx;
    logic [EW-1:0] w_werr_nx;

    assign w_p        = ~(r_h[31] ^ r_h[21] ^ r_h[1] ^ r_h[0]);
    assign w_mis      = in_bit != w_p;
    assign w_err      = in_valid && (r_state == S_LOCKED) && w_mis;
    assign w_match_nx = r_match + 8'd1;
    assign w_werr_nx  = r_win_errs + EW'(1);

    // Sync FSM: fill history, verify predictions, then flywheel while locked
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_SEARCH;
            r_h        <= '0;
            r_fill     <= '0;
            r_match    <= '0;
            r_win      <= '0;
            r_win_errs <= '0;
        end else if (in_valid) begin
            case (r_state)
                S_SEARCH: begin
                    r_h    <= {r_h[30:0], in_bit};
                    r_fill <= r_fill + 5'd1;
                    if (r_fill == 5'd31) begin
                        r_state <= S_VERIFY;
                        r_match <= '0;
                    end
                end
                S_VERIFY: begin
                    r_h <= {r_h[30:0], in_bit};
                    if (!w_mis && r_h != '1) begin
                        r_match <= w_match_nx;
                        if (w_match_nx == LC) begin
                            r_state    <= S_LOCKED;
                            r_win      <= '0;
                            r_win_errs <= '0;
                        end
                    end else begin
                        r_match <= '0;
                    end
                end
                default: begin
                    r_h <= {r_h[30:0], w_p};
                    if (w_mis && w_werr_nx == UE) begin
                        r_state <= S_SEARCH;
                        r_fill  <= '0;
                    end else if (r_win == WLAST) begin
                        r_win      <= '0;
                        r_win_errs <= '0;
                    end else begin
                        r_win <= r_win + WW'(1);
                        if (w_mis) r_win_errs <= w_werr_nx;
                    end
                end
            endcase
        end
    end

    // Error pulse and saturating error counter; clear beats a coincident error
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_bit_err   <= w_err;
            r_err_count <= clear_err ? '0 : (w_err && r_err_count != '1) ? r_err_count + 32'd1 : r_err_count;
        end
    end

    assign locked     = r_state == S_LOCKED;
    assign bit_err    = r_bit_err;
    assign err_count  = r_err_count;
    assign sync_state = r_state;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed checks of lfsr_checker against a generator model
module tb_lfsr_checker;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clear_err = 1'b0;
    logic        locked;
    logic        bit_err;
    logic [31:0] err_count;
    logic [1:0]  sync_state;
    logic [31:0] g = '0;
    int          k = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    lfsr_checker dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .clear_err  (clear_err),
        .locked     (locked),
        .bit_err    (bit_err),
        .err_count  (err_count),
        .sync_state (sync_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: generator advances only on valid cycles; flip inverts the sent bit
    task automatic step(input logic v, input logic flip, input logic clr);
        logic nb;
        @(negedge clock);
        in_valid  = v;
        clear_err = clr;
        if (v) begin
            nb     = ~(g[31] ^ g[21] ^ g[1] ^ g[0]);
            g      = {g[30:0], nb};
            in_bit = nb ^ flip;
            k++;
        end else begin
            in_bit = 1'($urandom_range(0, 1));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        clear_err = 1'b0;
        g         = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic saw_lock;
        int   vcnt;
        int   idle;
        logic v;
        do_reset();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_bit_err", 32'(bit_err), 32'd0);
        chk("rst_err_count", err_count, 32'd0);
        chk("rst_state", 32'(sync_state), 32'd0);

        for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 1'b0);
        chk("fill_31_state", 32'(sync_state), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("fill_32_state", 32'(sync_state), 32'd1);
        for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 1'b0);
        chk("clean_63_locked", 32'(locked), 32'd0);
        chk("clean_63_state", 32'(sync_state), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("clean_64_locked", 32'(locked), 32'd1);
        chk("clean_64_state", 32'(sync_state), 32'd2);
        k = 0;
        for (int i = 0; i < 10000; i++) step(1'b1, 1'b0, 1'b0);
        chk("clean_10k_errs", err_count, 32'd0);
        chk("clean_10k_locked", 32'(locked), 32'd1);

        step(1'b1, 1'b1, 1'b0);
        chk("single_pulse", 32'(bit_err), 32'd1);
        chk("single_count", err_count, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("single_pulse_end", 32'(bit_err), 32'd0);
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
        chk("single_after_count", err_count, 32'd1);
        chk("single_after_locked", 32'(locked), 32'd1);

        step(1'b0, 1'b0, 1'b1);
        chk("clear_idle", err_count, 32'd0);
        chk("clear_idle_locked", 32'(locked), 32'd1);
        while (k % 64 != 0) step(1'b1, 1'b0, 1'b0);
        for (int e = 0; e < 7; e++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("burst_7_locked", 32'(locked), 32'd1);
        chk("burst_7_count", err_count, 32'd7);
        step(1'b1, 1'b1, 1'b0);
        chk("burst_8_locked", 32'(locked), 32'd0);
        chk("burst_8_state", 32'(sync_state), 32'd0);
        chk("burst_8_count", err_count, 32'd8);
        for (int i = 0; i < 63; i++) step(1'b1, 1'b0, 1'b0);
        chk("relock_63", 32'(locked), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("relock_64", 32'(locked), 32'd1);
        chk("relock_count", err_count, 32'd8);
        step(1'b1, 1'b1, 1'b1);
        chk("clear_on_err_count", err_count, 32'd0);
        chk("clear_on_err_pulse", 32'(bit_err), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("post_clear_count", err_count, 32'd1);

        #3 reset_n = 1'b0;
        #1;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_bit_err", 32'(bit_err), 32'd0);
        chk("async_count", err_count, 32'd0);
        chk("async_state", 32'(sync_state), 32'd0);

        do_reset();
        vcnt = 0;
        idle = 0;
        while (vcnt < 63) begin
            v = 1'($urandom_range(0, 1)) | (idle >= 4);
            idle = v ? 0 : idle + 1;
            step(v, 1'b0, 1'b0);
            if (v) vcnt++;
        end
        chk("gap_63_locked", 32'(locked), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("gap_idle_state", 32'(sync_state), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("gap_64_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("gap_errs", err_count, 32'd0);
        chk("gap_still_locked", 32'(locked), 32'd1);

        do_reset();
        saw_lock = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_bit   = 1'b1;
            @(posedge clock);
            #1;
            if (locked) saw_lock = 1'b1;
        end
        chk("stuck_state", 32'(sync_state), 32'd1);
        chk("stuck_never_locked", 32'(saw_lock), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 32-bit LFSR pseudo-random sequence generator. It consumes the generator's serial output bit stream, self-synchronises a local copy of the same XNOR LFSR to it, and then flags and counts bit errors. It sits at the far end of a link or loopback path under test, and runs in the same clock domain as the generator.

## Interface
Parameters:
- LOCK_COUNT, 32: consecutive correct predictions required in VERIFY before declaring lock (1..255).
- WINDOW, 64: length, in valid bits, of the loss-of-lock error window (2..1024).
- UNLOCK_ERRS, 8: errors within one window that force loss of lock (1..WINDOW).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample in_bit this cycle; tie to the generator's enable.
- in_bit  in  1  received serial bit; the generator's out_bit.
- clear_err  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- bit_err  out  1  one-cycle pulse per mismatching bit while LOCKED.
- err_count  out  32  saturating count of errors seen while LOCKED.
- sync_state  out  2  0 = SEARCH, 1 = VERIFY, 2 = LOCKED.

## Operation
- **History register h[31:0].** On every valid bit it updates as h <= {h[30:0], b}.
- **Prediction.** The expected next bit is p = ~(h[31] ^ h[21] ^ h[1] ^ h[0]). This is the same tap set as the generator.
- **Idle cycles.** Cycles with in_valid = 0 change nothing.
- **SEARCH**
  - Shift in_bit into h and increment fill_cnt.
  - On the 32nd valid bit, go to VERIFY with match_cnt = 0.
  - No comparisons are made.
- **VERIFY**
  - Shift in_bit into h, which keeps the checker self-synchronising.
  - If in_bit == p and h != 32'hFFFF_FFFF, increment match_cnt.
  - Otherwise, set match_cnt = 0. The all-ones state is the XNOR lockup state and must never yield lock, so a stuck-at-1 line stays in VERIFY.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED with win_cnt = 0 and win_errs = 0.
  - Errors here are not counted and do not pulse bit_err.
- **LOCKED (flywheel)**
  - Shift p into h instead of in_bit, so a single error does not propagate.
  - If in_bit != p:
    - pulse bit_err;
    - increment err_count, saturating at 32'hFFFF_FFFF;
    - increment win_errs.
  - win_cnt counts valid bits from 0 to WINDOW-1. When the bit at WINDOW-1 has been processed, win_cnt and win_errs both return to 0.
  - If win_errs, including the current bit, reaches UNLOCK_ERRS, go to SEARCH with fill_cnt = 0 and drop locked. This check takes precedence over the window wrap.
- **clear_err**
  - Sets err_count to 0.
  - If it coincides with an error, clear wins and the result is 0.
  - It does not affect state, win_errs, or bit_err.
- **Reset (reset_n low)**
  - Asynchronously sets h = 0, state = SEARCH, and all counters = 0.
  - Outputs go to locked = 0, bit_err = 0, err_count = 0, sync_state = 0.
  - A mid-lock reset discards lock and the error count immediately.

## Timing
- All outputs are registered.
- A mismatch on the valid bit sampled at edge N gives bit_err = 1 during the cycle after edge N. err_count shows the incremented value in that same cycle.
- locked and sync_state change on the same edge that samples the deciding bit.
- Lock latency with a clean stream: 32 fill bits + LOCK_COUNT verify bits. With default parameters, locked rises on the edge that samples the 64th valid bit.
- Idle cycles (in_valid low) stretch latency but do not alter results.
- Unlock happens on the edge sampling the UNLOCK_ERRS-th error of a window.
- Relock needs a full SEARCH + VERIFY pass.

## Test plan
- **Reset:** hold reset_n low, then release. Required: locked = 0, bit_err = 0, err_count = 0, sync_state = 0. Assert reset_n mid-lock: all outputs return to these values asynchronously.
- **Clean lock:** generator from zero state with enable = 1, connected to in_bit/in_valid. Required: locked rises on the 64th valid bit, and err_count = 0 after 10,000 bits.
- **Single error:** while locked, invert one bit. Required: exactly one bit_err pulse, err_count = 1, locked stays 1, and no further errors.
- **Gapped stream:** drive enable/in_valid with a random 50% pattern. Required: locked after 64 valid bits and zero errors.
- **Error burst:** invert 8 bits within 20 consecutive valid bits. Required: locked falls on the 8th error, err_count = 8, and relock occurs 64 clean valid bits later with err_count still 8. Then assert clear_err on an error bit: err_count = 0.
- **Stuck-at-1 input:** drive in_bit = 1 constantly for 1,000 valid bits. Required: sync_state stays at 1 and locked never asserts.
